// File: rtl/scene_sequencer.sv
// Purpose: per-frame animation sequencer (countdown -> logo scroll-out -> head slide-in -> play)
//          that drives the layer offsets and enables for the sprite compositor.
// Latency: vsync/button edges are synchronised, and state updates 2 clk edges after the first high sample.
// Backpressure: none; a vsync edge is one tick, and presses outside PLAY are dropped.
// Ports: clk, rst (async, active-high); vsync, btn_left and btn_right are raw async inputs;
//        restart is a sync one-cycle clear. logo/head h/v offsets are 12-bit signed.
//        logo_en and head_en are the layer visibility enables. phase is 0..3, and play_frames saturates.
// Optional macro LANE_GLIDE_EN: head_hoffset glides toward the lane target by GLIDE_STEP per tick.
module scene_sequencer #(
  parameter int COUNT_INIT = 50,
  parameter int LOGO_STEP  = 5,
  parameter int LOGO_END   = -600,
  parameter int HEAD_START = -170,
  parameter int HEAD_STEP  = 10,
  parameter int LANE_DX    = 100,
  parameter int GLIDE_STEP = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               restart,
  output logic signed [11:0] logo_hoffset,
  output logic signed [11:0] head_hoffset,
  output logic signed [11:0] head_voffset,
  output logic               logo_en,
  output logic               head_en,
  output logic [1:0]         phase,
  output logic [15:0]        play_frames
);

  typedef enum logic [1:0] {COUNTDOWN = 2'd0, LOGO = 2'd1, HEAD = 2'd2, PLAY = 2'd3} phase_t;
  typedef enum logic [1:0] {LANE_LEFT = 2'd0, LANE_CENTER = 2'd1, LANE_RIGHT = 2'd2} lane_t;

  // Clamp arithmetic is done one bit wider so a step can never wrap past the limit.
  localparam logic signed [12:0] LOGO_STEP13 = 13'(LOGO_STEP);
  localparam logic signed [12:0] LOGO_END13  = 13'(LOGO_END);
  localparam logic signed [12:0] HEAD_STEP13 = 13'(HEAD_STEP);

  // Sync chains: [0] is the first flop, [1] is the synchronised value, and [2] is the delay for edge detection.
  logic [2:0] vs_sync, bl_sync, br_sync;
  logic       tick, press_l, press_r;

  assign tick    = vs_sync[1] & ~vs_sync[2];
  assign press_l = bl_sync[1] & ~bl_sync[2];
  assign press_r = br_sync[1] & ~br_sync[2];

  phase_t             phase_q, phase_nxt;
  lane_t              lane_q, lane_nxt;
  logic [15:0]        countdown_q, countdown_nxt;
  logic signed [11:0] logo_nxt, head_h_nxt, head_v_nxt;
  logic               logo_en_nxt, head_en_nxt;
  logic [15:0]        play_frames_nxt;

  logic signed [12:0] logo_dec, head_inc;
  assign logo_dec = 13'(logo_hoffset) - LOGO_STEP13;
  assign head_inc = 13'(head_voffset) + HEAD_STEP13;

  assign phase = phase_q;

  function automatic logic signed [12:0] lane_target(lane_t l);
    case (l)
      LANE_LEFT:  return 13'(LANE_DX);
      LANE_RIGHT: return -13'(LANE_DX);
      default:    return 13'sd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_sync      <= '0;
      bl_sync      <= '0;
      br_sync      <= '0;
      phase_q      <= COUNTDOWN;
      lane_q       <= LANE_CENTER;
      countdown_q  <= 16'(COUNT_INIT);
      logo_hoffset <= '0;
      head_hoffset <= '0;
      head_voffset <= 12'(HEAD_START);
      logo_en      <= 1'b1;
      head_en      <= 1'b0;
      play_frames  <= '0;
    end else begin
      if (restart) begin
        vs_sync <= '0;
        bl_sync <= '0;
        br_sync <= '0;
      end else begin
        vs_sync <= {vs_sync[1:0], vsync};
        bl_sync <= {bl_sync[1:0], btn_left};
        br_sync <= {br_sync[1:0], btn_right};
      end
      phase_q      <= phase_nxt;
      lane_q       <= lane_nxt;
      countdown_q  <= countdown_nxt;
      logo_hoffset <= logo_nxt;
      head_hoffset <= head_h_nxt;
      head_voffset <= head_v_nxt;
      logo_en      <= logo_en_nxt;
      head_en      <= head_en_nxt;
      play_frames  <= play_frames_nxt;
    end
  end

  always_comb begin
    logic signed [12:0] tgt;
    logic signed [12:0] cur;
    phase_nxt       = phase_q;
    lane_nxt        = lane_q;
    countdown_nxt   = countdown_q;
    logo_nxt        = logo_hoffset;
    head_h_nxt      = head_hoffset;
    head_v_nxt      = head_voffset;
    logo_en_nxt     = logo_en;
    head_en_nxt     = head_en;
    play_frames_nxt = play_frames;
    tgt             = 13'sd0;
    cur             = 13'(head_hoffset);

    if (restart) begin
      phase_nxt       = COUNTDOWN;
      lane_nxt        = LANE_CENTER;
      countdown_nxt   = 16'(COUNT_INIT);
      logo_nxt        = '0;
      head_h_nxt      = '0;
      head_v_nxt      = 12'(HEAD_START);
      logo_en_nxt     = 1'b1;
      head_en_nxt     = 1'b0;
      play_frames_nxt = '0;
    end else begin
      if (tick) begin
        unique case (phase_q)
          COUNTDOWN: begin
            if (countdown_q <= 16'd1) phase_nxt = LOGO;
            if (countdown_q != 16'd0) countdown_nxt = countdown_q - 16'd1;
          end
          LOGO: begin
            if (logo_dec <= LOGO_END13) begin
              logo_nxt    = 12'(LOGO_END13);
              phase_nxt   = HEAD;
              head_en_nxt = 1'b1;
            end else begin
              logo_nxt = 12'(logo_dec);
            end
          end
          HEAD: begin
            if (head_inc >= 13'sd0) begin
              head_v_nxt  = '0;
              phase_nxt   = PLAY;
              logo_en_nxt = 1'b0;
            end else begin
              head_v_nxt = 12'(head_inc);
            end
          end
          PLAY: begin
            if (play_frames != 16'hFFFF) play_frames_nxt = play_frames + 16'd1;
          end
        endcase
      end

      // A simultaneous left+right press cancels out.
      if (phase_q == PLAY && (press_l ^ press_r)) begin
        case (lane_q)
          LANE_LEFT:   lane_nxt = press_r ? LANE_CENTER : LANE_LEFT;
          LANE_CENTER: lane_nxt = press_r ? LANE_RIGHT  : LANE_LEFT;
          LANE_RIGHT:  lane_nxt = press_r ? LANE_RIGHT  : LANE_CENTER;
          default:     lane_nxt = LANE_CENTER;
        endcase
      end

      // The target follows the post-press lane, so a press in the middle of a glide retargets immediately.
      tgt = lane_target(lane_nxt);
`ifdef LANE_GLIDE_EN
      if (tick) begin
        if (cur < tgt)
          head_h_nxt = (cur + 13'(GLIDE_STEP) > tgt) ? 12'(tgt) : 12'(cur + 13'(GLIDE_STEP));
        else if (cur > tgt)
          head_h_nxt = (cur - 13'(GLIDE_STEP) < tgt) ? 12'(tgt) : 12'(cur - 13'(GLIDE_STEP));
      end
`else
      head_h_nxt = 12'(tgt);
      if (cur == tgt) head_h_nxt = head_hoffset;
`endif
    end
  end

endmodule
